// File: rtl/sync_pkg.sv
// Shared definitions for the sync strobe generator: state encoding and default widths.
package sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } sync_state_e;

    localparam int SYNC_PERIOD_W  = 16;
    localparam int SYNC_WIDTH_W   = 8;
    localparam int SYNC_CNT_W     = 16;
    localparam int SYNC_MIN_WIDTH = 1;

endpackage

// File: rtl/sync_ack_mon.sv
// Ack-window tracker: one window per sync pulse, sticky miss flag when a window closes unacknowledged.
module sync_ack_mon
    import sync_pkg::*;
(
    input  logic sys_clk,
    input  logic rst_n,
    input  logic i_rise,
    input  logic i_idle,
    input  logic i_ack,
    input  logic i_clr_miss,
    output logic o_miss
);

    logic open_q, open_d;
    logic miss_q, miss_d;
    logic miss_evt;

    always_comb begin
        miss_evt = open_q && (i_rise || i_idle);
        open_d   = open_q;
        // An ack coinciding with a rise belongs to the window that rise opens.
        if (i_rise) begin
            open_d = !i_ack;
        end else if (i_idle) begin
            open_d = 1'b0;
        end else if (i_ack) begin
            open_d = 1'b0;
        end

        miss_d = miss_q;
        if (miss_evt) begin
            miss_d = 1'b1;
        end else if (i_clr_miss) begin
            miss_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            open_q <= open_d;
            miss_q <= miss_d;
        end
    end

    assign o_miss = miss_q;

endmodule

// File: rtl/sync_pulse_gen.sv
// Periodic sync strobe generator: programmable width/period, finite or free-running trains.
//   state   | meaning
//   IDLE    | no train active, waiting for start
//   HIGH    | o_sync asserted, timing pulse width
//   LOW     | o_sync deasserted, timing remainder of period
module sync_pulse_gen
    import sync_pkg::*;
#(
    parameter int PERIOD_W = SYNC_PERIOD_W,
    parameter int WIDTH_W  = SYNC_WIDTH_W,
    parameter int CNT_W    = SYNC_CNT_W
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic [WIDTH_W-1:0]  i_width,
    input  logic [CNT_W-1:0]    i_count,
    input  logic                i_ack,
    input  logic                i_clr_miss,
    output logic                o_sync,
    output logic                o_busy,
    output logic                o_done,
    output logic [CNT_W-1:0]    o_pulse_num,
    output logic                o_miss
);

    // One extra bit so that width+1 never overflows when clamping the period.
    localparam int TW = ((PERIOD_W > WIDTH_W) ? PERIOD_W : WIDTH_W) + 1;

    sync_state_e      state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [TW-1:0]    width_q, width_d;
    logic [TW-1:0]    period_q, period_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pulse_num_q, pulse_num_d;
    logic             stop_pend_q, stop_pend_d;
    logic             sync_q, sync_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rise_q, rise_d;

    logic [TW-1:0]    w_eff;
    logic [TW-1:0]    p_eff;
    logic             train_end;

    always_comb begin
        w_eff = TW'(i_width);
        if (w_eff < TW'(SYNC_MIN_WIDTH)) begin
            w_eff = TW'(SYNC_MIN_WIDTH);
        end
        p_eff = TW'(i_period);
        if (p_eff <= w_eff) begin
            p_eff = w_eff + TW'(1);
        end
    end

    assign train_end = stop_pend_q || i_stop ||
                       ((count_q != '0) && (pulse_num_q == count_q));

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        width_d     = width_q;
        period_d    = period_q;
        count_d     = count_q;
        pulse_num_d = pulse_num_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;
        rise_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    width_d     = w_eff;
                    period_d    = p_eff;
                    count_d     = i_count;
                    pulse_num_d = '0;
                    stop_pend_d = 1'b0;
                    timer_d     = w_eff - TW'(1);
                    rise_d      = 1'b1;
                    state_d     = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (rise_q) begin
                    pulse_num_d = pulse_num_q + CNT_W'(1);
                end
                if (i_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (timer_q == '0) begin
                    timer_d = period_q - width_q - TW'(1);
                    state_d = ST_LOW;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_LOW: begin
                if (i_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (timer_q == '0) begin
                    if (train_end) begin
                        stop_pend_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        timer_d = width_q - TW'(1);
                        rise_d  = 1'b1;
                        state_d = ST_HIGH;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        sync_d = (state_d == ST_HIGH);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            width_q     <= '0;
            period_q    <= '0;
            count_q     <= '0;
            pulse_num_q <= '0;
            stop_pend_q <= 1'b0;
            sync_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rise_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            width_q     <= width_d;
            period_q    <= period_d;
            count_q     <= count_d;
            pulse_num_q <= pulse_num_d;
            stop_pend_q <= stop_pend_d;
            sync_q      <= sync_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rise_q      <= rise_d;
        end
    end

    // rise_q marks the first HIGH cycle, done_q the first IDLE cycle after a train.
    sync_ack_mon u_ack_mon (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .i_rise     (rise_q),
        .i_idle     (done_q),
        .i_ack      (i_ack),
        .i_clr_miss (i_clr_miss),
        .o_miss     (o_miss)
    );

    assign o_sync      = sync_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_pulse_num = pulse_num_q;

endmodule

// File: tb/tb_sync_pulse_gen.sv
// Bench for sync_pulse_gen: per-cycle comparison against a closed-form model of each train.
module tb_sync_pulse_gen;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        i_start, i_stop, i_ack, i_clr_miss;
    logic [15:0] i_period;
    logic [7:0]  i_width;
    logic [15:0] i_count;
    logic        o_sync, o_busy, o_done, o_miss;
    logic [15:0] o_pulse_num;

    int   total = 0;
    int   bad   = 0;
    int   cur_t = 0;
    logic miss_m = 1'b0;
    int   pn_m   = 0;

    always #5 sys_clk = ~sys_clk;

    sync_pulse_gen dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_period    (i_period),
        .i_width     (i_width),
        .i_count     (i_count),
        .i_ack       (i_ack),
        .i_clr_miss  (i_clr_miss),
        .o_sync      (o_sync),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_pulse_num (o_pulse_num),
        .o_miss      (o_miss)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, cur_t, obs, exp);
        end
    endtask

    task automatic chk_all(input logic s, input logic b, input logic d, input int pn, input logic m);
        chk("sync", {31'd0, o_sync}, {31'd0, s});
        chk("busy", {31'd0, o_busy}, {31'd0, b});
        chk("done", {31'd0, o_done}, {31'd0, d});
        chk("pulse_num", {16'd0, o_pulse_num}, 32'(pn));
        chk("miss", {31'd0, o_miss}, {31'd0, m});
    endtask

    task automatic idle_inputs();
        i_start = 1'b0; i_stop = 1'b0; i_ack = 1'b0; i_clr_miss = 1'b0;
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Cycle 0 carries the start request; pulse k rises in cycle 1+k*P and the train
    // returns to IDLE (done) in cycle 1+N*P. An unacked pulse sets miss in cycle r_k+P+1.
    task automatic run_train(input int p_in, input int w_in, input int n_in,
                             input int stop_pulse, input logic [7:0] nack, input int fixed_dly);
        int w, p, ne, d, t_stop, t_sbusy, pn_e;
        int dly[8];
        logic ack, me, s_e;
        w  = (w_in < 1) ? 1 : w_in;
        p  = (p_in < w + 1) ? w + 1 : p_in;
        if (n_in == 0) ne = stop_pulse + 1;
        else if (stop_pulse >= 0 && stop_pulse + 1 < n_in) ne = stop_pulse + 1;
        else ne = n_in;
        d       = 1 + ne * p;
        t_stop  = (stop_pulse >= 0) ? 1 + stop_pulse * p : -1;
        t_sbusy = (d >= 4) ? $urandom_range(2, d - 2) : -1;
        for (int k = 0; k < 8; k++) dly[k] = (fixed_dly >= 0) ? fixed_dly : $urandom_range(0, p - 1);
        for (int t = 0; t <= d + 2; t++) begin
            @(negedge sys_clk);
            cur_t = t;
            s_e  = (t >= 1) && (t <= d - 1) && (((t - 1) % p) < w);
            pn_e = (t == 0) ? pn_m : (t == 1) ? 0 : imin(ne, (t - 2) / p + 1);
            me   = miss_m;
            for (int k = 0; k < ne; k++)
                if (nack[k] && t >= 1 + k * p + p + 1) me = 1'b1;
            chk_all(s_e, (t >= 1) && (t <= d - 1), (t == d), pn_e, me);

            i_start = (t == 0) || (t == t_sbusy);
            i_stop  = (t == t_stop);
            if (t == 0) begin
                i_period = 16'(p_in); i_width = 8'(w_in); i_count = 16'(n_in);
            end else begin
                i_period = 16'($urandom); i_width = 8'($urandom); i_count = 16'($urandom);
            end
            ack = 1'b0;
            for (int k = 0; k < ne; k++)
                if (!nack[k] && t == 1 + k * p + dly[k]) ack = 1'b1;
            if (t == 0 || t == d) ack = ack | 1'($urandom % 2);
            i_ack = ack;
        end
        idle_inputs();
        miss_m = me;
        pn_m   = ne;
    endtask

    task automatic clear_miss();
        @(negedge sys_clk);
        i_clr_miss = 1'b1;
        @(negedge sys_clk);
        i_clr_miss = 1'b0;
        cur_t = -1;
        chk("miss_clear", {31'd0, o_miss}, 32'd0);
        miss_m = 1'b0;
    endtask

    initial begin
        int p, w, n, sp;
        rst_n = 1'b0;
        idle_inputs();
        i_period = 16'd0; i_width = 8'd0; i_count = 16'd0;
        #12;
        chk_all(1'b0, 1'b0, 1'b0, 0, 1'b0);
        #10 rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        chk_all(1'b0, 1'b0, 1'b0, 0, 1'b0);

        run_train(256, 1, 3, -1, 8'h00, 4);
        run_train(2, 5, 3, -1, 8'h00, -1);
        run_train(10, 2, 0, 3, 8'h00, -1);
        run_train(7, 3, 4, -1, 8'h02, -1);
        clear_miss();

        @(negedge sys_clk);
        i_start = 1'b1; i_stop = 1'b1; i_period = 16'd5; i_width = 8'd2; i_count = 16'd1;
        @(negedge sys_clk);
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            cur_t = i;
            chk_all(1'b0, 1'b0, 1'b0, pn_m, miss_m);
            @(negedge sys_clk);
        end

        for (int i = 0; i < 8; i++) begin
            p = $urandom_range(2, 30);
            w = $urandom_range(0, 12);
            n = $urandom_range(0, 4);
            if (n == 0) sp = $urandom_range(0, 3);
            else sp = ($urandom % 3 == 0) ? $urandom_range(0, n - 1) : -1;
            run_train(p, w, n, sp, 8'($urandom), -1);
            if (miss_m) clear_miss();
        end

        // Free-running train with no acks, then asynchronous reset in the middle of it.
        @(negedge sys_clk);
        i_start = 1'b1; i_period = 16'd20; i_width = 8'd5; i_count = 16'd0;
        @(negedge sys_clk);
        idle_inputs();
        repeat (36) @(negedge sys_clk);
        cur_t = 37;
        chk("pre_rst_busy", {31'd0, o_busy}, 32'd1);
        chk("pre_rst_miss", {31'd0, o_miss}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_all(1'b0, 1'b0, 1'b0, 0, 1'b0);
        #9 rst_n = 1'b1;
        miss_m = 1'b0;
        pn_m   = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge sys_clk);
            cur_t = i;
            chk_all(1'b0, 1'b0, 1'b0, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_pulse_gen.md
Name: sync_pulse_gen

Overview:
Generates the periodic sync strobe consumed by clock_sync on its i_sync input, in the sys_clk (100 MHz) domain. It produces programmable-width, programmable-period pulse trains, either finite or free-running. It also monitors a per-pulse acknowledge returned from the downstream clock_sync path and flags lost syncs.

Parameters:
PERIOD_W, 16, width of period register (sys_clk cycles between sync rising edges)
WIDTH_W, 8, width of pulse-width register (cycles o_sync is high)
CNT_W, 16, width of pulse-count register and pulse counter

Ports:
sys_clk  input  1  system clock, 100 MHz; only clock
rst_n  input  1  asynchronous active-low reset
i_start  input  1  single-cycle request to start a pulse train
i_stop  input  1  single-cycle request to end the train after the current pulse
i_period  input  PERIOD_W  cycles between rising edges; sampled on accepted start
i_width  input  WIDTH_W  pulse high time in cycles; sampled on accepted start
i_count  input  CNT_W  pulses to emit; 0 = free-running; sampled on accepted start
i_ack  input  1  acknowledge from downstream, already in sys_clk domain
i_clr_miss  input  1  clears o_miss
o_sync  output  1  sync strobe to clock_sync i_sync
o_busy  output  1  high while a train is active (any state except IDLE)
o_done  output  1  one-cycle pulse on return to IDLE
o_pulse_num  output  CNT_W  count of pulses emitted in current/last train
o_miss  output  1  sticky: a pulse was not acknowledged before the next rising edge

Behaviour:
- Reset (async, rst_n=0): state IDLE; o_sync=0, o_busy=0, o_done=0, o_pulse_num=0, o_miss=0; internal counters 0.
- States: IDLE, HIGH, LOW.
- IDLE: i_start=1 and i_stop=0 -> latch params, clear o_pulse_num, go HIGH next cycle. i_start with i_stop in the same cycle -> stay IDLE (stop wins).
- Timing: o_sync rises exactly 1 cycle after the accepted start.
- Effective width W = max(i_width,1). Effective period P = max(i_period, W+1).
- HIGH: o_sync=1 for exactly W cycles.
  - o_pulse_num increments in the first HIGH cycle; wraps modulo 2^CNT_W in free-run.
  - After W cycles -> LOW.
- LOW: o_sync=0 for P-W cycles, so rising edges are exactly P cycles apart.
- End of LOW:
  - If stop is pending, or i_count!=0 and o_pulse_num==i_count -> IDLE, with o_done=1 for 1 cycle in the first IDLE cycle.
  - Otherwise -> HIGH.
- i_stop while busy: sets a pending flag. The current pulse is never truncated; the LOW gap still completes before IDLE.
- i_start while busy: ignored.
- Parameter inputs: changes during a train are ignored until the next accepted start.
- Ack window: opens at each rising edge of o_sync and closes at the next rising edge, or at return to IDLE.
  - The first i_ack in the window closes it.
  - If the window closes without an ack, o_miss is set the cycle after closure.
  - i_ack outside a window is ignored.
- i_clr_miss clears o_miss next cycle. If a miss is detected in the same cycle as i_clr_miss, set wins.
- Single-pulse train: i_count=1 produces one pulse then IDLE. Its ack window closes at IDLE entry.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package sync_pkg:
  - state encoding (IDLE=2'd0, HIGH=2'd1, LOW=2'd2)
  - default widths
  - constant SYNC_MIN_WIDTH=1
- One sub-module, sync_ack_mon: ack-window tracker and sticky miss flag. Inputs: rise strobe, idle-entry strobe, i_ack, i_clr_miss. Output: o_miss.
- Top holds the FSM and counters.

Test Plan:
1. Reset mid-train, with rst_n low for 10 ns at an arbitrary point -> all outputs 0 asynchronously; after release, no o_sync until a new i_start.
2. i_period=256, i_width=1, i_count=3, i_ack pulsed 4 cycles after each rise:
   - o_sync rises 1 cycle after start, then at +256 and +512.
   - o_pulse_num ends at 3; o_done fires at cycle start+769; o_miss stays 0.
3. i_period=2, i_width=5 (clamped to P=6):
   - o_sync high for 5 cycles, low for 1; rising edges 6 cycles apart.
4. i_count=0, i_period=10, i_width=2, i_stop asserted in the 1st HIGH cycle of pulse 4:
   - pulse 4 completes its full 2 high and 8 low cycles; then IDLE; o_done=1; o_pulse_num=4.
5. i_ack withheld for pulse 2 of a 4-pulse train:
   - o_miss=1 one cycle after pulse 3 rises and stays set; i_clr_miss then clears it.
6. i_start and i_stop together in IDLE -> no pulse, o_busy stays 0. Then i_start while busy -> no restart, and pulse timing is unchanged.
